// File: rtl/cdb_arb.sv
// Common data bus arbiter: one small FIFO per result source (EX, LSB), round-robin
// grant into a registered broadcast stage. Flush and stall apply to both buffers.
module cdb_arb #(
  parameter int FIFO_D    = 2,
  parameter int REG_DAT_W = 32,
  parameter int ROB_ADD_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iClr,
  input  logic                 iEX_En,
  input  logic [ROB_ADD_W-1:0] iEX_Qd,
  input  logic [REG_DAT_W-1:0] iEX_Vd,
  output logic                 oEX_Rdy,
  input  logic                 iLSB_En,
  input  logic [ROB_ADD_W-1:0] iLSB_Qd,
  input  logic [REG_DAT_W-1:0] iLSB_Vd,
  output logic                 oLSB_Rdy,
  output logic                 oCDB_En,
  output logic [ROB_ADD_W-1:0] oCDB_Qd,
  output logic [REG_DAT_W-1:0] oCDB_Vd
);

  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic                 w_go;
  logic                 w_sel_lsb;
  logic [1:0]           w_in_en;
  logic [1:0]           w_rdy;
  logic [1:0]           w_push;
  logic [1:0]           w_pop;
  logic [1:0]           w_nempty;
  logic [ROB_ADD_W-1:0] w_in_qd   [2];
  logic [REG_DAT_W-1:0] w_in_vd   [2];
  logic [ROB_ADD_W-1:0] w_head_qd [2];
  logic [REG_DAT_W-1:0] w_head_vd [2];

  logic                 r_rr;
  logic                 r_cdb_en;
  logic [ROB_ADD_W-1:0] r_cdb_qd;
  logic [REG_DAT_W-1:0] r_cdb_vd;

  assign w_in_en    = {iLSB_En, iEX_En};
  assign w_in_qd[0] = iEX_Qd;
  assign w_in_qd[1] = iLSB_Qd;
  assign w_in_vd[0] = iEX_Vd;
  assign w_in_vd[1] = iLSB_Vd;

  assign w_go = en && !iClr;

  // LSB wins only when it has data and either EX is empty or it holds priority
  assign w_sel_lsb = w_nempty[1] && (!w_nempty[0] || r_rr);
  assign w_pop[0]  = w_go && w_nempty[0] && !w_sel_lsb;
  assign w_pop[1]  = w_go && w_sel_lsb;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [ROB_ADD_W-1:0] r_mem_qd [FIFO_D];
      logic [REG_DAT_W-1:0] r_mem_vd [FIFO_D];
      logic [PTR_W-1:0]     r_wr_ptr;
      logic [PTR_W-1:0]     r_rd_ptr;
      logic [CNT_W-1:0]     r_cnt;

      // Readiness depends on registered occupancy only: a full FIFO never
      // accepts, even in a cycle where it is being popped.
      assign w_rdy[gi]     = w_go && (r_cnt < CNT_W'(FIFO_D));
      assign w_push[gi]    = w_in_en[gi] && w_rdy[gi] && (w_in_qd[gi] != '0);
      assign w_nempty[gi]  = (r_cnt != '0);
      assign w_head_qd[gi] = r_mem_qd[r_rd_ptr];
      assign w_head_vd[gi] = r_mem_vd[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem_qd[r_wr_ptr] <= w_in_qd[gi];
          r_mem_vd[r_wr_ptr] <= w_in_vd[gi];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else if (iClr) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_cnt    <= '0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
          if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
          r_cnt <= r_cnt + CNT_W'(w_push[gi]) - CNT_W'(w_pop[gi]);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr     <= 1'b0;
      r_cdb_en <= 1'b0;
      r_cdb_qd <= '0;
      r_cdb_vd <= '0;
    end else if (iClr) begin
      r_rr     <= 1'b0;
      r_cdb_en <= 1'b0;
    end else if (en && (w_nempty != 2'b00)) begin
      r_cdb_en <= 1'b1;
      r_cdb_qd <= w_sel_lsb ? w_head_qd[1] : w_head_qd[0];
      r_cdb_vd <= w_sel_lsb ? w_head_vd[1] : w_head_vd[0];
      // Priority moves to whichever source lost (or was absent) this grant
      r_rr     <= !w_sel_lsb;
    end else begin
      r_cdb_en <= 1'b0;
    end
  end

  assign oEX_Rdy  = w_rdy[0];
  assign oLSB_Rdy = w_rdy[1];
  assign oCDB_En  = r_cdb_en;
  assign oCDB_Qd  = r_cdb_qd;
  assign oCDB_Vd  = r_cdb_vd;

endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb: per-cycle vector table plus hand-written sequences
// for flush, backpressure and asynchronous reset.
module tb_cdb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        iClr;
  logic        iEX_En;
  logic [4:0]  iEX_Qd;
  logic [31:0] iEX_Vd;
  logic        oEX_Rdy;
  logic        iLSB_En;
  logic [4:0]  iLSB_Qd;
  logic [31:0] iLSB_Vd;
  logic        oLSB_Rdy;
  logic        oCDB_En;
  logic [4:0]  oCDB_Qd;
  logic [31:0] oCDB_Vd;

  int n_run  = 0;
  int n_fail = 0;

  cdb_arb #(.FIFO_D(2), .REG_DAT_W(32), .ROB_ADD_W(5)) dut (
    .clk(clk), .rst(rst), .en(en), .iClr(iClr),
    .iEX_En(iEX_En), .iEX_Qd(iEX_Qd), .iEX_Vd(iEX_Vd), .oEX_Rdy(oEX_Rdy),
    .iLSB_En(iLSB_En), .iLSB_Qd(iLSB_Qd), .iLSB_Vd(iLSB_Vd), .oLSB_Rdy(oLSB_Rdy),
    .oCDB_En(oCDB_En), .oCDB_Qd(oCDB_Qd), .oCDB_Vd(oCDB_Vd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic        ex_en;
    logic [4:0]  ex_qd;
    logic [31:0] ex_vd;
    logic        lsb_en;
    logic [4:0]  lsb_qd;
    logic [31:0] lsb_vd;
    logic        x_rdy;
    logic        l_rdy;
    logic        c_en;
    logic [4:0]  c_qd;
    logic [31:0] c_vd;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  function automatic vec_t mk(logic e, logic c, logic xe, logic [4:0] xq, logic [31:0] xv,
                              logic le, logic [4:0] lq, logic [31:0] lv,
                              logic xr, logic lr, logic ce, logic [4:0] cq, logic [31:0] cv);
    vec_t v;
    v.en = e; v.clr = c; v.ex_en = xe; v.ex_qd = xq; v.ex_vd = xv;
    v.lsb_en = le; v.lsb_qd = lq; v.lsb_vd = lv;
    v.x_rdy = xr; v.l_rdy = lr; v.c_en = ce; v.c_qd = cq; v.c_vd = cv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic c, input logic xe, input logic [4:0] xq,
                       input logic [31:0] xv, input logic le, input logic [4:0] lq,
                       input logic [31:0] lv);
    en = e; iClr = c; iEX_En = xe; iEX_Qd = xq; iEX_Vd = xv;
    iLSB_En = le; iLSB_Qd = lq; iLSB_Vd = lv;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One broadcast-free idle cycle, checked
  task automatic idle_quiet(input string nm);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk(nm, 32'(oCDB_En), 32'd0);
  endtask

  initial begin
    // Table: state after reset is empty FIFOs, EX preferred.
    vt[0]  = mk(1,0, 1,5'd3,32'h11,   0,5'd0,32'h0,    1,1, 1'b0,5'd0,32'h0);
    vt[1]  = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b1,5'd3,32'h11);
    vt[2]  = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b0,5'd3,32'h11);
    vt[3]  = mk(1,1, 0,5'd0,32'h0,    0,5'd0,32'h0,    0,0, 1'b0,5'd3,32'h11);
    vt[4]  = mk(1,0, 1,5'd1,32'hA1,   1,5'd9,32'hB9,   1,1, 1'b0,5'd3,32'h11);
    vt[5]  = mk(1,0, 1,5'd2,32'hA2,   1,5'd10,32'hBA,  1,1, 1'b1,5'd1,32'hA1);
    vt[6]  = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,0, 1'b1,5'd9,32'hB9);
    vt[7]  = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b1,5'd2,32'hA2);
    vt[8]  = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b1,5'd10,32'hBA);
    vt[9]  = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b0,5'd10,32'hBA);
    vt[10] = mk(1,0, 1,5'd0,32'h55,   0,5'd0,32'h0,    1,1, 1'b0,5'd10,32'hBA);
    vt[11] = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b0,5'd10,32'hBA);
    vt[12] = mk(0,0, 1,5'd4,32'hC4,   0,5'd0,32'h0,    0,0, 1'b0,5'd10,32'hBA);
    vt[13] = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b0,5'd10,32'hBA);
    vt[14] = mk(1,0, 1,5'd5,32'hC5,   0,5'd0,32'h0,    1,1, 1'b0,5'd10,32'hBA);
    vt[15] = mk(0,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    0,0, 1'b0,5'd10,32'hBA);
    vt[16] = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b1,5'd5,32'hC5);
    vt[17] = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b0,5'd5,32'hC5);
    vt[18] = mk(1,0, 0,5'd0,32'h0,    1,5'd7,32'h77,   1,1, 1'b0,5'd5,32'hC5);
    vt[19] = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b1,5'd7,32'h77);
    vt[20] = mk(1,0, 0,5'd0,32'h0,    0,5'd0,32'h0,    1,1, 1'b0,5'd7,32'h77);

    // Reset state, checked while reset is held
    rst = 1'b0;
    idle();
    #2;
    chk("rst_cdb_en", 32'(oCDB_En), 32'd0);
    chk("rst_cdb_qd", 32'(oCDB_Qd), 32'd0);
    chk("rst_cdb_vd", oCDB_Vd, 32'd0);
    chk("rst_ex_rdy_en1", 32'(oEX_Rdy), 32'd1);
    chk("rst_lsb_rdy_en1", 32'(oLSB_Rdy), 32'd1);
    en = 1'b0; #1;
    chk("rst_ex_rdy_en0", 32'(oEX_Rdy), 32'd0);
    chk("rst_lsb_rdy_en0", 32'(oLSB_Rdy), 32'd0);
    reset_dut();

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].en, vt[i].clr, vt[i].ex_en, vt[i].ex_qd, vt[i].ex_vd,
            vt[i].lsb_en, vt[i].lsb_qd, vt[i].lsb_vd);
      #1;
      chk($sformatf("v%0d_ex_rdy", i), 32'(oEX_Rdy), 32'(vt[i].x_rdy));
      chk($sformatf("v%0d_lsb_rdy", i), 32'(oLSB_Rdy), 32'(vt[i].l_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_cdb_en", i), 32'(oCDB_En), 32'(vt[i].c_en));
      chk($sformatf("v%0d_cdb_qd", i), 32'(oCDB_Qd), 32'(vt[i].c_qd));
      chk($sformatf("v%0d_cdb_vd", i), oCDB_Vd, vt[i].c_vd);
      $display("[TB] vec %0d: cdb_en=%0d qd=%0d vd=%0h", i, oCDB_En, oCDB_Qd, oCDB_Vd);
    end

    // Flush with entries buffered in both sources
    reset_dut();
    @(negedge clk); drive(1,0, 1,5'd11,32'h111, 1,5'd21,32'h121);
    @(posedge clk); #1; chk("fl_a_en", 32'(oCDB_En), 32'd0);
    @(negedge clk); drive(1,0, 1,5'd12,32'h112, 1,5'd22,32'h122);
    @(posedge clk); #1;
    chk("fl_b_en", 32'(oCDB_En), 32'd1);
    chk("fl_b_qd", 32'(oCDB_Qd), 32'd11);
    @(negedge clk); drive(1,1, 1,5'd13,32'h113, 1,5'd23,32'h123);
    #1;
    chk("fl_ex_rdy", 32'(oEX_Rdy), 32'd0);
    chk("fl_lsb_rdy", 32'(oLSB_Rdy), 32'd0);
    @(posedge clk); #1;
    chk("fl_c_en", 32'(oCDB_En), 32'd0);
    chk("fl_c_qd_hold", 32'(oCDB_Qd), 32'd11);
    $display("[TB] flush applied");
    for (int k = 0; k < 4; k++) idle_quiet($sformatf("fl_quiet%0d", k));
    @(negedge clk); drive(1,0, 1,5'd14,32'h114, 1,5'd24,32'h124);
    @(posedge clk); #1; chk("fl_post_en0", 32'(oCDB_En), 32'd0);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("fl_post_qd1", 32'(oCDB_Qd), 32'd14);
    chk("fl_post_en1", 32'(oCDB_En), 32'd1);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("fl_post_qd2", 32'(oCDB_Qd), 32'd24);
    chk("fl_post_en2", 32'(oCDB_En), 32'd1);
    $display("[TB] post-flush broadcasts 14 then 24 checked");

    // Backpressure: EX always offering, LSB offers three; sources hold until ready
    begin
      int ei = 0;
      int li = 0;
      logic ex_acc, l_acc;
      logic [4:0] obs [$];
      logic [4:0] ex_seen [$];
      logic [4:0] l_seen [$];
      reset_dut();
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        drive(1,0, (ei < 8), 5'(ei + 1), 32'(ei + 1), (li < 3), 5'(17 + li), 32'(17 + li));
        #1;
        if (c == 1) chk("bp_lsb_rdy_c1", 32'(oLSB_Rdy), 32'd1);
        if (c == 2) chk("bp_lsb_rdy_full", 32'(oLSB_Rdy), 32'd0);
        ex_acc = iEX_En && oEX_Rdy;
        l_acc  = iLSB_En && oLSB_Rdy;
        @(posedge clk);
        if (ex_acc) ei++;
        if (l_acc) li++;
        #1;
        if (oCDB_En) begin
          obs.push_back(oCDB_Qd);
          $display("[TB] bp cycle %0d broadcast tag %0d", c, oCDB_Qd);
        end
      end
      chk("bp_total", 32'(obs.size()), 32'd11);
      foreach (obs[k]) begin
        if (obs[k] >= 5'd17) l_seen.push_back(obs[k]);
        else ex_seen.push_back(obs[k]);
      end
      chk("bp_lsb_count", 32'(l_seen.size()), 32'd3);
      for (int k = 0; k < 3; k++)
        if (k < l_seen.size()) chk($sformatf("bp_lsb_order%0d", k), 32'(l_seen[k]), 32'(17 + k));
      for (int k = 0; k < 8; k++)
        if (k < ex_seen.size()) chk($sformatf("bp_ex_order%0d", k), 32'(ex_seen[k]), 32'(k + 1));
    end

    // Asynchronous reset while a broadcast is showing and LSB data is buffered
    reset_dut();
    @(negedge clk); drive(1,0, 1,5'd5,32'h55, 1,5'd6,32'h66);
    @(posedge clk); #1;
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("ar_pre_en", 32'(oCDB_En), 32'd1);
    chk("ar_pre_qd", 32'(oCDB_Qd), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("ar_en", 32'(oCDB_En), 32'd0);
    chk("ar_qd", 32'(oCDB_Qd), 32'd0);
    chk("ar_vd", oCDB_Vd, 32'd0);
    $display("[TB] async reset asserted mid-cycle");
    @(negedge clk); rst = 1'b1;
    for (int k = 0; k < 4; k++) idle_quiet($sformatf("ar_quiet%0d", k));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arb.md
CDB_ARB -- requirements
Module: cdb_arb

Interface
REQ-001 Parameter: FIFO_D, default 2, depth of each per-source result buffer (power of two, >=2).
REQ-002 Parameter: REG_DAT_W, default 32, result data width.
REQ-003 Parameter: ROB_ADD_W, default 5, ROB tag width; tag 0 means "no producer".
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 en  input  1  global stall; 0 freezes buffers.
REQ-007 iClr  input  1  synchronous flush (branch mispredict).
REQ-008 iEX_En  input  1  EX result valid.
REQ-009 iEX_Qd  input  ROB_ADD_W  EX result tag.
REQ-010 iEX_Vd  input  REG_DAT_W  EX result value.
REQ-011 oEX_Rdy  output  1  EX buffer can accept this cycle.
REQ-012 iLSB_En  input  1  LSB result valid.
REQ-013 iLSB_Qd  input  ROB_ADD_W  LSB result tag.
REQ-014 iLSB_Vd  input  REG_DAT_W  LSB result value.
REQ-015 oLSB_Rdy  output  1  LSB buffer can accept this cycle.
REQ-016 oCDB_En  output  1  broadcast valid, one-cycle pulse per result.
REQ-017 oCDB_Qd  output  ROB_ADD_W  broadcast tag.
REQ-018 oCDB_Vd  output  REG_DAT_W  broadcast value.

Function
REQ-019 Block SHALL share one common data bus (consumed by RS, ROB, LSB) between EX and LSB via one FIFO_D-entry FIFO per source plus a registered output stage.
REQ-020 oX_Rdy SHALL equal en && !iClr && (count_X < FIFO_D), count from registered state only; no pass-through when full even if popping.
REQ-021 Push: edge with iX_En && oX_Rdy && iX_Qd != 0 SHALL write {Qd,Vd} at tail; iX_En with Qd == 0 SHALL be accepted and discarded.
REQ-022 Push while oX_Rdy == 0 SHALL be ignored; source holds its data (sources must hold until Rdy).
REQ-023 Grant: each edge with en && !iClr, if any FIFO non-empty, exactly one head SHALL be popped into the output register and oCDB_En set to 1; otherwise oCDB_En set to 0.
REQ-024 Arbitration SHALL be round-robin via 1-bit rrPtr (0 = EX preferred, 1 = LSB preferred); only one FIFO non-empty -> grant it regardless of rrPtr.
REQ-025 After any grant rrPtr SHALL point to the non-granted source.
REQ-026 Simultaneous push and pop on same FIFO SHALL leave count unchanged; pointers wrap modulo FIFO_D.
REQ-027 Latency: result accepted at edge t into empty FIFO, with the other source idle, SHALL appear on oCDB_* after edge t+1 (for one cycle).
REQ-028 Per-source ordering SHALL be FIFO; no result dropped or duplicated except by REQ-021 or flush.
REQ-029 en == 0: no push, no pop, rrPtr held, oCDB_En cleared to 0 at next edge (no repeat broadcast).
REQ-030 iClr == 1 (overrides en): at next edge both FIFOs emptied, oCDB_En = 0, rrPtr = 0; inputs that cycle discarded.
REQ-031 oCDB_Qd/oCDB_Vd SHALL hold last granted values while oCDB_En == 0.

Reset
REQ-032 rst == 0 SHALL immediately, without a clock: empty both FIFOs, clear rrPtr, oCDB_En/oCDB_Qd/oCDB_Vd = 0.
REQ-033 During reset oEX_Rdy/oLSB_Rdy SHALL read 0 when en == 0 and otherwise reflect empty FIFOs; first accept allowed at first edge after release.
REQ-034 Reset asserted mid-operation SHALL discard all buffered results; no broadcast of pre-reset data after release.

Verification
REQ-035 Single: EX pushes Qd=3,Vd=0x11 at edge 1 -> edge 2 oCDB_En=1,Qd=3,Vd=0x11; edge 3 oCDB_En=0.
REQ-036 Contention: both push every cycle (EX tags 1,2; LSB tags 9,10) from reset -> broadcast order 1,9,2,10, one per cycle.
REQ-037 Backpressure: FIFO_D=2, LSB pushes 3 results while EX continuously fed -> oLSB_Rdy low when LSB count=2; all 3 LSB tags eventually broadcast in order.
REQ-038 Tag zero: iEX_En=1,Qd=0 -> oEX_Rdy=1, no broadcast follows.
REQ-039 Flush: 2 entries buffered per source, iClr=1 one cycle -> oCDB_En=0 next edge, no buffered tag ever broadcast, next EX push broadcast with EX preferred.
REQ-040 Async reset: rst low between edges with oCDB_En=1 -> oCDB_En=0 immediately; after release no stale broadcast.
